instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 14 +
 rtl/instruction_fetch.sv | 98 +++++++++
 2 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package instruction_fetch_pkg;

  localparam int unsigned DefaultAddressWidth = 8;
  localparam int unsigned DefaultDataWidth    = 8;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    REDIRECT,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch FSM: reads one instruction at pc, offers it downstream, and steers an external
// program counter through registered increment / load strobes.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DefaultAddressWidth,
  parameter int unsigned DATA_WIDTH    = DefaultDataWidth
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  output logic                     pc_enable,
  output logic                     pc_load_n,
  output logic [ADDRESS_WIDTH-1:0] jump_address,
  output logic                     mem_read,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  input  logic                     mem_ready,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     branch_taken,
  input  logic [ADDRESS_WIDTH-1:0] branch_target,
  input  logic                     halt
);

  fetch_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0]    instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [ADDRESS_WIDTH-1:0] jump_address_q, jump_address_d;
  logic                     pc_enable_q, pc_enable_d;
  logic                     pc_load_n_q, pc_load_n_d;

  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    jump_address_d = jump_address_q;
    pc_enable_d    = 1'b0;
    pc_load_n_d    = 1'b1;
    unique case (state_q)
      FETCH: begin
        // A redirect wins over returning data; the data is simply dropped.
        if (branch_taken) begin
          state_d        = REDIRECT;
          pc_load_n_d    = 1'b0;
          jump_address_d = branch_target;
        end else if (mem_ready) begin
          state_d     = HOLD;
          instr_d     = mem_data;
          instr_pc_d  = pc;
          pc_enable_d = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          state_d        = REDIRECT;
          pc_load_n_d    = 1'b0;
          jump_address_d = branch_target;
        end else if (instr_ready) begin
          state_d = halt ? HALTED : FETCH;
        end
      end
      REDIRECT: state_d = FETCH;
      HALTED:   state_d = HALTED;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= FETCH;
      instr_q        <= '0;
      instr_pc_q     <= '0;
      jump_address_q <= '0;
      pc_enable_q    <= 1'b0;
      pc_load_n_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      instr_pc_q     <= instr_pc_d;
      jump_address_q <= jump_address_d;
      pc_enable_q    <= pc_enable_d;
      pc_load_n_q    <= pc_load_n_d;
    end
  end

  assign mem_read     = (state_q == FETCH) && !reset;
  assign mem_address  = pc;
  assign instr_valid  = (state_q == HOLD);
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign jump_address = jump_address_q;
  assign pc_enable    = pc_enable_q;
  assign pc_load_n    = pc_load_n_q;

endmodule
